// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_isa_pkg
// Description : Shared MIPS ISA definitions: assembler operation classes,
//               opcode/funct encodings and assembler error codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_isa_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_BNE  = 4'd8,
        OP_ADDI = 4'd9,
        OP_ORI  = 4'd10,
        OP_J    = 4'd11
    } instr_op_e;

    localparam logic [5:0] c_OPC_RTYPE = 6'b000000;
    localparam logic [5:0] c_OPC_LW    = 6'b100011;
    localparam logic [5:0] c_OPC_SW    = 6'b101011;
    localparam logic [5:0] c_OPC_BEQ   = 6'b000100;
    localparam logic [5:0] c_OPC_BNE   = 6'b000101;
    localparam logic [5:0] c_OPC_ADDI  = 6'b001000;
    localparam logic [5:0] c_OPC_ORI   = 6'b001101;
    localparam logic [5:0] c_OPC_J     = 6'b000010;

    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    localparam logic [1:0] c_ERR_NONE  = 2'b00;
    localparam logic [1:0] c_ERR_OP    = 2'b01;
    localparam logic [1:0] c_ERR_ALIGN = 2'b10;
    localparam logic [1:0] c_ERR_RANGE = 2'b11;

endpackage
`default_nettype wire

// File: rtl/instr_field_enc.sv
`default_nettype none
// ============================================================================
// Module      : instr_field_enc
// Description : Combinational packer from symbolic instruction to 32-bit MIPS
//               word, with alignment/range/opcode error detection.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_field_enc
    import mips_isa_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [31:0] target,
    input  logic [31:0] pc,
    output logic [31:0] word,
    output logic [1:0]  errCode
);

    logic [31:0]        w_pcNext;
    logic signed [31:0] w_diff;
    logic signed [31:0] w_offset;
    logic               w_offInRange;
    logic               w_misaligned;
    logic               w_jInRegion;

    assign w_pcNext     = pc + 32'd4;
    assign w_diff       = signed'(target - w_pcNext);
    assign w_offset     = w_diff >>> 2;
    // Offset fits a signed 16-bit field only if bits [31:15] are a pure sign run.
    assign w_offInRange = (w_offset[31:15] == {17{w_offset[15]}});
    assign w_misaligned = (target[1:0] != 2'b00);
    assign w_jInRegion  = (target[31:28] == w_pcNext[31:28]);

    always_comb begin
        word    = '0;
        errCode = c_ERR_NONE;
        case (op)
            OP_ADD:  word = {c_OPC_RTYPE, rs, rt, rd, 5'd0, c_FN_ADD};
            OP_SUB:  word = {c_OPC_RTYPE, rs, rt, rd, 5'd0, c_FN_SUB};
            OP_AND:  word = {c_OPC_RTYPE, rs, rt, rd, 5'd0, c_FN_AND};
            OP_OR:   word = {c_OPC_RTYPE, rs, rt, rd, 5'd0, c_FN_OR};
            OP_SLT:  word = {c_OPC_RTYPE, rs, rt, rd, 5'd0, c_FN_SLT};
            OP_LW:   word = {c_OPC_LW,   rs, rt, imm};
            OP_SW:   word = {c_OPC_SW,   rs, rt, imm};
            OP_ADDI: word = {c_OPC_ADDI, rs, rt, imm};
            OP_ORI:  word = {c_OPC_ORI,  rs, rt, imm};
            OP_BEQ, OP_BNE: begin
                word = {(op == OP_BEQ) ? c_OPC_BEQ : c_OPC_BNE, rs, rt, w_offset[15:0]};
                if (w_misaligned) begin
                    errCode = c_ERR_ALIGN;
                end else if (!w_offInRange) begin
                    errCode = c_ERR_RANGE;
                end
            end
            OP_J: begin
                word = {c_OPC_J, target[27:2]};
                if (w_misaligned) begin
                    errCode = c_ERR_ALIGN;
                end else if (!w_jInRegion) begin
                    errCode = c_ERR_RANGE;
                end
            end
            default: errCode = c_ERR_OP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_assembler.sv
`default_nettype none
// ============================================================================
// Module      : instr_assembler
// Description : Handshaked MIPS instruction assembler writing encoded words
//               into instruction memory at an auto-incrementing address.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_assembler
    import mips_isa_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [31:0]              start_addr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    input  logic [15:0]              in_imm,
    input  logic [31:0]              in_target,
    output logic                     imem_we,
    output logic [31:0]              imem_addr,
    output logic [31:0]              imem_wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     err,
    output logic [1:0]               err_code
);

    localparam int              c_CW        = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_WR   = 2'd2;
    localparam logic [1:0] c_ST_ERR  = 2'd3;

    logic [1:0]      r_state;
    logic [31:0]     r_wptr;
    logic [c_CW-1:0] r_count;
    logic            r_wePend;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_err;
    logic [1:0]      r_errCode;

    logic [31:0]     w_word;
    logic [1:0]      w_errCode;
    logic            w_full;
    logic            w_accept;

    instr_field_enc u_enc (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .pc      (r_wptr),
        .word    (w_word),
        .errCode (w_errCode)
    );

    assign w_full   = (r_count == c_DEPTH_CNT);
    // start overrides everything, so an instruction offered alongside it is refused.
    assign in_ready = (r_state == c_ST_RUN) && !w_full && !start;
    assign w_accept = in_valid && in_ready;

    assign imem_we    = r_wePend && !start;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign full       = w_full;
    assign err        = r_err;
    assign err_code   = r_errCode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_wptr    <= '0;
            r_count   <= '0;
            r_wePend  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_errCode <= c_ERR_NONE;
        end else if (start) begin
            r_state   <= c_ST_RUN;
            r_wptr    <= start_addr & ~32'd3;
            r_count   <= '0;
            r_wePend  <= 1'b0;
            r_err     <= 1'b0;
            r_errCode <= c_ERR_NONE;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_accept) begin
                        if (w_errCode != c_ERR_NONE) begin
                            r_state   <= c_ST_ERR;
                            r_err     <= 1'b1;
                            r_errCode <= w_errCode;
                        end else begin
                            r_state  <= c_ST_WR;
                            r_wePend <= 1'b1;
                            r_addr   <= r_wptr;
                            r_wdata  <= w_word;
                        end
                    end
                end
                c_ST_WR: begin
                    r_state  <= c_ST_RUN;
                    r_wePend <= 1'b0;
                    r_count  <= r_count + c_ONE;
                    // Pointer stays on the final word once the session fills up.
                    if (r_count != c_DEPTH_CNT - c_ONE) begin
                        r_wptr <= r_wptr + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_assembler
// Description : Scoreboard bench for instr_assembler (DEPTH=4) with directed,
//               hand-encoded instruction vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_assembler;
    import mips_isa_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] start_addr;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [31:0] in_target;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [$clog2(DEPTH):0] count;
    logic        full;
    logic        err;
    logic [1:0]  err_code;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t expQ[$];
    int  nChecks = 0;
    int  nFails  = 0;

    instr_assembler #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Write monitor: every observed write must match the oldest expectation.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                if (expQ.size() == 0) begin
                    check("unexpected_write_addr", imem_addr, 32'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    check("write_addr", imem_addr, e.addr);
                    check("write_data", imem_wdata, e.data);
                end
            end
        end
    end

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doStart(input logic [31:0] a);
        start      = 1'b1;
        start_addr = a;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] tgt,
                        input bit expWr, input logic [31:0] eAddr, input logic [31:0] eData);
        bit got;
        int n;
        wr_t e;
        got = 1'b0;
        n   = 0;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_target = tgt;
        in_valid = 1'b1;
        while (!got && n < 20) begin
            @(negedge clk);
            if (in_ready === 1'b1) got = 1'b1;
            n++;
        end
        check("accept_within_budget", {31'd0, got}, 32'd1);
        if (got) begin
            if (expWr) begin
                e.addr = eAddr;
                e.data = eData;
                expQ.push_back(e);
            end
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_addr = '0; in_valid = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_imem_we", {31'd0, imem_we}, 32'd0);
        check("reset_imem_addr", imem_addr, 32'd0);
        check("reset_imem_wdata", imem_wdata, 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_full", {31'd0, full}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_err_code", {30'd0, err_code}, 32'd0);
        nextCycle();

        // Basic program fills the 4-word session.
        doStart(32'h0);
        send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 1'b1, 32'h0, 32'h0022_1820);
        nextCycle();
        check("count_after_add", 32'(count), 32'd1);
        send(OP_BEQ, 5'd1, 5'd2, 5'd0, 16'h0, 32'h0, 1'b1, 32'h4, 32'h1022_FFFE);
        send(OP_J, 5'd0, 5'd0, 5'd0, 16'h0, 32'h40, 1'b1, 32'h8, 32'h0800_0010);
        send(OP_LW, 5'd29, 5'd8, 5'd0, 16'h0010, 32'h0, 1'b1, 32'hC, 32'h8FA8_0010);
        nextCycle();
        @(negedge clk);
        check("count_full_session", 32'(count), 32'd4);
        check("full_flag", {31'd0, full}, 32'd1);
        check("in_ready_when_full", {31'd0, in_ready}, 32'd0);
        nextCycle();

        // Encode errors.
        doStart(32'h0);
        check("count_cleared_by_start", 32'(count), 32'd0);
        send(OP_BEQ, 5'd1, 5'd2, 5'd0, 16'h0, 32'h0004_0000, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("err_range_flag", {31'd0, err}, 32'd1);
        check("err_range_code", {30'd0, err_code}, 32'd3);
        check("err_count_unchanged", 32'(count), 32'd0);
        repeat (3) @(negedge clk);
        check("in_ready_held_in_err", {31'd0, in_ready}, 32'd0);
        check("err_sticky", {31'd0, err}, 32'd1);
        nextCycle();
        doStart(32'h0);
        check("err_cleared_by_start", {31'd0, err}, 32'd0);
        send(OP_BNE, 5'd1, 5'd2, 5'd0, 16'h0, 32'h6, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("err_align_code", {30'd0, err_code}, 32'd2);
        nextCycle();
        doStart(32'h0);
        send(4'hF, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("err_unknown_op_code", {30'd0, err_code}, 32'd1);
        nextCycle();
        doStart(32'h0);
        send(OP_J, 5'd0, 5'd0, 5'd0, 16'h0, 32'h1000_0000, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("err_j_region_code", {30'd0, err_code}, 32'd3);
        nextCycle();
        doStart(32'h0);
        check("err_clear_final", {31'd0, err}, 32'd0);
        check("count_clear_final", 32'(count), 32'd0);

        // Back-to-back stream with in_valid held: only DEPTH words land.
        in_op = OP_ADD; in_rs = 5'd6; in_rt = 5'd7; in_rd = 5'd5;
        for (int i = 0; i < 4; i++) begin
            wr_t e;
            e.addr = 32'(i * 4);
            e.data = 32'h00C7_2820;
            expQ.push_back(e);
        end
        in_valid = 1'b1;
        repeat (12) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("stream_count", 32'(count), 32'd4);
        check("stream_full", {31'd0, full}, 32'd1);
        check("stream_in_ready", {31'd0, in_ready}, 32'd0);
        check("stream_queue_drained", 32'(expQ.size()), 32'd0);
        nextCycle();

        // Misaligned start address, then the remaining classes.
        doStart(32'h203);
        send(OP_SUB, 5'd5, 5'd6, 5'd4, 16'h0, 32'h0, 1'b1, 32'h200, 32'h00A6_2022);
        nextCycle();
        doStart(32'h1000);
        send(OP_SW, 5'd2, 5'd3, 5'd0, 16'hFFFC, 32'h0, 1'b1, 32'h1000, 32'hAC43_FFFC);
        send(OP_ADDI, 5'd0, 5'd9, 5'd0, 16'h8000, 32'h0, 1'b1, 32'h1004, 32'h2009_8000);
        send(OP_SLT, 5'd11, 5'd12, 5'd10, 16'h0, 32'h0, 1'b1, 32'h1008, 32'h016C_502A);
        send(OP_BNE, 5'd3, 5'd4, 5'd0, 16'h0, 32'h1030, 1'b1, 32'h100C, 32'h1464_0008);
        nextCycle();

        // start during the write cycle drops that write.
        doStart(32'h300);
        send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        start = 1'b1;
        start_addr = 32'h400;
        @(negedge clk);
        check("start_in_wr_we", {31'd0, imem_we}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        check("start_in_wr_count", 32'(count), 32'd0);
        send(OP_ORI, 5'd1, 5'd2, 5'd0, 16'hABCD, 32'h0, 1'b1, 32'h400, 32'h3422_ABCD);
        nextCycle();
        check("count_after_restart", 32'(count), 32'd1);

        // Asynchronous reset in the write cycle.
        send(OP_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        #1 rst = 1'b1;
        #1;
        check("rst_wr_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_wr_imem_addr", imem_addr, 32'd0);
        check("rst_wr_imem_wdata", imem_wdata, 32'd0);
        check("rst_wr_count", 32'(count), 32'd0);
        check("rst_wr_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_wr_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("final_queue_empty", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
